// File: rtl/mux_nt1_pipe.sv
// N:1 registered multiplexer with valid/ready on every channel and on the output.
// Per cycle, either the external select or a fair round-robin scan chooses the channel.
module mux_nt1_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(2**SEL_W)*DATA_W-1:0]  in_data,
  input  logic [(2**SEL_W)-1:0]         in_valid,
  output logic [(2**SEL_W)-1:0]         in_ready,
  input  logic [SEL_W-1:0]              sel,
  input  logic                          mode,
  output logic [DATA_W-1:0]             out_data,
  output logic [SEL_W-1:0]              out_sel,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned N = 2 ** SEL_W;

  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  sel_q;
  logic              valid_q;
  logic [SEL_W-1:0]  ptr_q;

  logic              load_en;
  logic              rr_found;
  logic [SEL_W-1:0]  rr_idx;
  logic [SEL_W-1:0]  scan_idx;
  logic [SEL_W-1:0]  grant;
  logic              req;
  logic              xfer;

  assign load_en = !valid_q || out_ready;

  // Scan from the farthest offset down so the nearest valid channel after ptr wins;
  // SEL_W-bit addition wraps modulo N.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    scan_idx = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      scan_idx = ptr_q + SEL_W'(i);
      if (in_valid[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    if (mode) begin
      grant = rr_idx;
      req   = rr_found;
    end else begin
      grant = sel;
      req   = in_valid[sel];
    end
  end

  assign xfer = load_en && req && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else if (xfer) begin
      data_q  <= in_data[grant*DATA_W +: DATA_W];
      sel_q   <= grant;
      valid_q <= 1'b1;
      if (mode) begin
        ptr_q <= grant + SEL_W'(1);
      end
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_nt1_pipe.sv
// Randomized and directed bench for mux_nt1_pipe against a queue-free behavioural model
// of the output register, the grant rules and the round-robin pointer.
module tb_mux_nt1_pipe;
  localparam int DW = 32;
  localparam int SW = 5;
  localparam int N  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [SW-1:0]   sel;
  logic            mode;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sel;
  logic            out_valid;
  logic            out_ready;

  mux_nt1_pipe #(.DATA_W(DW), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  bit          m_valid = 0;
  logic [DW-1:0] m_data = '0;
  int          m_sel = 0;
  int          m_ptr = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are already driven; check ready mid-cycle, cross the edge, check outputs.
  task automatic cycle();
    int g;
    bit req;
    logic [N-1:0] exp_rdy;
    #1;
    req = 0;
    g   = 0;
    if (mode) begin
      for (int i = 0; i < N; i++) begin
        if (!req && in_valid[(m_ptr + i) % N]) begin
          req = 1;
          g   = (m_ptr + i) % N;
        end
      end
    end else begin
      g   = int'(sel);
      req = in_valid[sel];
    end
    exp_rdy = '0;
    if (!rst && req && (!m_valid || out_ready)) exp_rdy[g] = 1'b1;
    check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      m_valid = 0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = 0;
    end else if (exp_rdy != '0) begin
      m_valid = 1;
      m_data  = in_data[g*DW +: DW];
      m_sel   = g;
      if (mode) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    check_eq("out_valid", 64'(out_valid), 64'(m_valid));
    check_eq("out_data", 64'(out_data), 64'(m_data));
    check_eq("out_sel", 64'(out_sel), 64'(m_sel));
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) in_data[k*DW +: DW] = $urandom;
  endtask

  initial begin
    int exp_seq[6];
    exp_seq = '{0, 7, 31, 0, 7, 31};
    rst = 1; mode = 1; sel = '0; out_ready = 1; in_valid = '1;
    rand_data();

    // Reset held two cycles with every channel valid
    repeat (2) begin
      cycle();
      check_eq("rst_in_ready", 64'(in_ready), 64'(0));
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_out_data", 64'(out_data), 64'(0));
      check_eq("rst_out_sel", 64'(out_sel), 64'(0));
    end
    rst = 0;
    cycle();
    check_eq("rr_first_grant", 64'(out_sel), 64'(0));

    // Fixed select on channel 17, sustained throughput
    mode = 0; sel = 5'd17;
    in_data[17*DW +: DW] = 32'hDEAD_BEEF;
    cycle();
    check_eq("fix_data", 64'(out_data), 64'h0000_0000_DEAD_BEEF);
    check_eq("fix_sel", 64'(out_sel), 64'd17);
    repeat (3) begin
      rand_data();
      cycle();
      check_eq("fix_tput_valid", 64'(out_valid), 64'd1);
    end

    // Backpressure on channel 3
    sel = 5'd3;
    in_data[3*DW +: DW] = 32'h0000_0003;
    cycle();
    out_ready = 0;
    in_data[3*DW +: DW] = 32'h0000_0099;
    repeat (4) begin
      cycle();
      check_eq("bp_data", 64'(out_data), 64'd3);
      check_eq("bp_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1;
    in_data[3*DW +: DW] = 32'h0000_0033;
    cycle();
    check_eq("bp_release", 64'(out_data), 64'h33);
    out_ready = 0;
    in_data[3*DW +: DW] = 32'h0000_0044;
    cycle();
    check_eq("bp_one_more", 64'(out_data), 64'h33);

    // Round-robin fairness and wrap from a clean pointer
    out_ready = 1; rst = 1;
    cycle();
    rst = 0; mode = 1;
    in_valid = '0;
    in_valid[0] = 1; in_valid[7] = 1; in_valid[31] = 1;
    for (int i = 0; i < 6; i++) begin
      rand_data();
      cycle();
      check_eq("rr_seq", 64'(out_sel), 64'(exp_seq[i]));
    end

    // Sparse scan: ptr=8 and only channel 2 valid
    rst = 1;
    cycle();
    rst = 0;
    in_valid = '0; in_valid[7] = 1;
    cycle();
    in_valid = '0; in_valid[2] = 1;
    cycle();
    check_eq("sparse_wrap", 64'(out_sel), 64'd2);
    in_valid = '0; in_valid[2] = 1; in_valid[3] = 1;
    cycle();
    check_eq("sparse_ptr3", 64'(out_sel), 64'd3);

    // Reset while a beat is stalled
    mode = 0; sel = 5'd4; in_valid = '1;
    in_data[4*DW +: DW] = 32'h1234_5678;
    cycle();
    out_ready = 0;
    cycle();
    check_eq("mid_held", 64'(out_data), 64'h1234_5678);
    rst = 1;
    cycle();
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_data", 64'(out_data), 64'd0);
    rst = 0; in_valid = '0; out_ready = 1;
    cycle();
    check_eq("mid_no_beat", 64'(out_valid), 64'd0);
    mode = 1; in_valid = '1;
    cycle();
    check_eq("mid_ptr0", 64'(out_sel), 64'd0);

    // Random soak
    for (int t = 0; t < 3000; t++) begin
      rst       = ($urandom_range(0, 59) == 0);
      mode      = $urandom_range(0, 1);
      sel       = SW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       in_valid = $urandom & $urandom & $urandom;
        1:       in_valid = $urandom;
        default: in_valid = 32'(1) << $urandom_range(0, N - 1);
      endcase
      rand_data();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
